// File: rtl/chess_pixel_renderer.sv
// Pixel-colour stage behind the VGA timing controller: board/glyph lookup, cursor border,
// selection highlight and registered RGB with sync/blank delayed to match (3 pix_en strobes).
module chess_pixel_renderer #(
    parameter int BOARD_X   = 40,
    parameter int BOARD_Y   = 40,
    parameter int BLINK_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        bright,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [5:0]  board_addr,
    input  logic [3:0]  board_data,
    output logic [12:0] glyph_addr,
    input  logic        glyph_bit,
    input  logic [5:0]  cursor_sq,
    input  logic [5:0]  select_sq,
    input  logic        select_valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hs_out,
    output logic        vs_out,
    output logic        blank_n_out
);

    logic [10:0] dx, dy;
    logic        c0_inside;
    logic [2:0]  c0_row, c0_col;
    logic [5:0]  c0_sx, c0_sy;

    // Square coordinates are forced to zero off-board so board_addr reads square 0 there.
    always_comb begin
        dx        = {1'b0, hcount} - 11'(BOARD_X);
        dy        = {1'b0, vcount} - 11'(BOARD_Y);
        c0_inside = ({1'b0, hcount} >= 11'(BOARD_X)) && (dx < 11'd320) &&
                    ({1'b0, vcount} >= 11'(BOARD_Y)) && (dy < 11'd320);
        c0_row = '0;
        c0_col = '0;
        c0_sx  = '0;
        c0_sy  = '0;
        if (c0_inside) begin
            c0_col = 3'(dx / 11'd40);
            c0_row = 3'(dy / 11'd40);
            c0_sx  = 6'(dx % 11'd40);
            c0_sy  = 6'(dy % 11'd40);
        end
    end

    logic       s0_inside, s0_bright, s0_hs, s0_vs, s0_cur, s0_sel;
    logic [2:0] s0_row, s0_col;
    logic [5:0] s0_sx, s0_sy;
    logic [7:0] frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_inside <= 1'b0;
            s0_bright <= 1'b0;
            s0_hs     <= 1'b1;
            s0_vs     <= 1'b1;
            s0_cur    <= 1'b0;
            s0_sel    <= 1'b0;
            s0_row    <= '0;
            s0_col    <= '0;
            s0_sx     <= '0;
            s0_sy     <= '0;
            frame_cnt <= '0;
        end else if (pix_en) begin
            s0_inside <= c0_inside;
            s0_bright <= bright;
            s0_hs     <= hs_in;
            s0_vs     <= vs_in;
            s0_cur    <= c0_inside && ({c0_row, c0_col} == cursor_sq);
            s0_sel    <= c0_inside && select_valid && ({c0_row, c0_col} == select_sq);
            s0_row    <= c0_row;
            s0_col    <= c0_col;
            s0_sx     <= c0_sx;
            s0_sy     <= c0_sy;
            if (s0_vs && !vs_in)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end

    assign board_addr = {s0_row, s0_col};

    logic       s1_inside, s1_bright, s1_hs, s1_vs, s1_cur, s1_sel, s1_dark;
    logic [3:0] s1_piece;
    logic [5:0] s1_sx, s1_sy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_inside <= 1'b0;
            s1_bright <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_cur    <= 1'b0;
            s1_sel    <= 1'b0;
            s1_dark   <= 1'b0;
            s1_piece  <= '0;
            s1_sx     <= '0;
            s1_sy     <= '0;
        end else if (pix_en) begin
            s1_inside <= s0_inside;
            s1_bright <= s0_bright;
            s1_hs     <= s0_hs;
            s1_vs     <= s0_vs;
            s1_cur    <= s0_cur;
            s1_sel    <= s0_sel;
            s1_dark   <= s0_row[0] ^ s0_col[0];
            s1_piece  <= board_data;
            s1_sx     <= s0_sx;
            s1_sy     <= s0_sy;
        end
    end

    logic s1_win, s1_border, glyph_on;
    logic [7:0] n_r, n_g, n_b;

    always_comb begin
        s1_win    = (s1_sx >= 6'd4) && (s1_sx < 6'd36) && (s1_sy >= 6'd4) && (s1_sy < 6'd36);
        s1_border = (s1_sx < 6'd2) || (s1_sx > 6'd37) || (s1_sy < 6'd2) || (s1_sy > 6'd37);
        glyph_on  = (s1_piece[2:0] != 3'd0) && (s1_piece[2:0] != 3'd7) && s1_win && glyph_bit;
        glyph_addr = '0;
        if (s1_inside && s1_win)
            glyph_addr = {s1_piece[2:0], 5'(s1_sy - 6'd4), 5'(s1_sx - 6'd4)};
        // First match wins: blank, off-board, cursor border, glyph, highlight, square.
        n_r = 8'd181; n_g = 8'd136; n_b = 8'd99;
        if (!s1_bright) begin
            n_r = 8'd0; n_g = 8'd0; n_b = 8'd0;
        end else if (!s1_inside) begin
            n_r = 8'd32; n_g = 8'd32; n_b = 8'd32;
        end else if (s1_cur && frame_cnt[BLINK_BIT] && s1_border) begin
            n_r = 8'd255; n_g = 8'd0; n_b = 8'd0;
        end else if (glyph_on) begin
            n_r = s1_piece[3] ? 8'd0 : 8'd255;
            n_g = n_r;
            n_b = n_r;
        end else if (s1_sel) begin
            n_r = 8'd246; n_g = 8'd246; n_b = 8'd105;
        end else if (!s1_dark) begin
            n_r = 8'd240; n_g = 8'd217; n_b = 8'd181;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hs_out      <= 1'b1;
            vs_out      <= 1'b1;
            blank_n_out <= 1'b0;
        end else if (pix_en) begin
            vga_r       <= n_r;
            vga_g       <= n_g;
            vga_b       <= n_b;
            hs_out      <= s1_hs;
            vs_out      <= s1_vs;
            blank_n_out <= s1_bright;
        end
    end

endmodule

// File: tb/tb_chess_pixel_renderer.sv
// Randomised bench for chess_pixel_renderer: board RAM / glyph ROM models, scoreboard of
// expected RGB+sync per pixel, computed from plain integer board geometry.
module tb_chess_pixel_renderer;
    localparam int BX = 40;
    localparam int BY = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pix_en = 1'b0;
    logic [9:0]  hcount = '0, vcount = '0;
    logic        bright = 1'b0, hs_in = 1'b1, vs_in = 1'b1;
    logic [5:0]  board_addr;
    logic [3:0]  board_data = '0;
    logic [12:0] glyph_addr;
    logic        glyph_bit = 1'b0;
    logic [5:0]  cursor_sq = '0, select_sq = '0;
    logic        select_valid = 1'b0;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hs_out, vs_out, blank_n_out;

    chess_pixel_renderer #(.BOARD_X(BX), .BOARD_Y(BY), .BLINK_BIT(4)) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .bright(bright), .hs_in(hs_in), .vs_in(vs_in), .board_addr(board_addr),
        .board_data(board_data), .glyph_addr(glyph_addr), .glyph_bit(glyph_bit),
        .cursor_sq(cursor_sq), .select_sq(select_sq), .select_valid(select_valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hs_out(hs_out), .vs_out(vs_out),
        .blank_n_out(blank_n_out)
    );

    // ---------------- clock / memories ----------------
    always #5 clk = ~clk;

    logic [3:0] board [64];
    logic       glyph_mem [8192];

    always @(posedge clk) begin
        board_data <= board[board_addr];
        glyph_bit  <= glyph_mem[glyph_addr];
    end

    // ---------------- reference model ----------------
    typedef struct {
        int h, v;
        bit bright, hs, vs, sel_valid;
        int cursor, select;
    } pix_t;

    int n_checks = 0, n_pass = 0;
    logic [26:0] exp_q[$];
    int   model_fc = 0;
    bit   prev_vs = 1'b1;
    bit   have_prev = 1'b0;
    pix_t prev;
    bit   cur_vs = 1'b1;
    int   offs[10] = '{0, 1, 2, 3, 4, 35, 36, 37, 38, 39};

    function automatic bit on_board(pix_t p);
        return (p.h >= BX) && (p.h < BX + 320) && (p.v >= BY) && (p.v < BY + 320);
    endfunction

    function automatic int square_of(pix_t p);
        return on_board(p) ? ((p.v - BY) / 40) * 8 + (p.h - BX) / 40 : 0;
    endfunction

    function automatic bit in_window(pix_t p);
        int sx = (p.h - BX) % 40;
        int sy = (p.v - BY) % 40;
        return on_board(p) && sx >= 4 && sx < 36 && sy >= 4 && sy < 36;
    endfunction

    function automatic int glyph_of(pix_t p);
        int typ = board[square_of(p)] % 8;
        if (!in_window(p)) return 0;
        return typ * 1024 + ((p.v - BY) % 40 - 4) * 32 + ((p.h - BX) % 40 - 4);
    endfunction

    function automatic logic [26:0] model(pix_t p, int fc);
        int r, g, b, sq, sx, sy, row, col, typ, colr;
        logic [26:0] res;
        sq  = square_of(p);
        row = sq / 8;
        col = sq % 8;
        sx  = (p.h - BX) % 40;
        sy  = (p.v - BY) % 40;
        typ = board[sq] % 8;
        colr = board[sq] / 8;
        if (!p.bright) begin
            r = 0; g = 0; b = 0;
        end else if (!on_board(p)) begin
            r = 32; g = 32; b = 32;
        end else if (sq == p.cursor && ((fc / 16) % 2 == 1) &&
                     (sx < 2 || sx > 37 || sy < 2 || sy > 37)) begin
            r = 255; g = 0; b = 0;
        end else if (typ >= 1 && typ <= 6 && in_window(p) && glyph_mem[glyph_of(p)]) begin
            r = colr ? 0 : 255; g = r; b = r;
        end else if (p.sel_valid && sq == p.select) begin
            r = 246; g = 246; b = 105;
        end else if ((row + col) % 2 == 0) begin
            r = 240; g = 217; b = 181;
        end else begin
            r = 181; g = 136; b = 99;
        end
        res = {r[7:0], g[7:0], b[7:0], p.hs, p.vs, p.bright};
        return res;
    endfunction

    function automatic pix_t mk(int h, int v, bit br, bit hs, bit vs, int cur, int sel, bit sv);
        pix_t p;
        p.h = h; p.v = v; p.bright = br; p.hs = hs; p.vs = vs;
        p.cursor = cur; p.select = sel; p.sel_valid = sv;
        return p;
    endfunction

    function automatic int pick_off();
        if ($urandom_range(0, 1) == 0) return offs[$urandom_range(0, 9)];
        return $urandom_range(0, 39);
    endfunction

    function automatic pix_t gen_pix();
        pix_t p;
        int sq = $urandom_range(0, 63);
        int m  = $urandom_range(0, 9);
        if (m < 8) begin
            p.h = BX + (sq % 8) * 40 + pick_off();
            p.v = BY + (sq / 8) * 40 + pick_off();
        end else if (m == 8) begin
            p.h = ($urandom_range(0, 1) == 0) ? BX + 320 : BX - 1;
            p.v = BY + $urandom_range(0, 319);
        end else begin
            p.h = $urandom_range(0, 799);
            p.v = $urandom_range(0, 524);
        end
        p.bright = $urandom_range(0, 9) != 0;
        p.hs     = $urandom_range(0, 7) != 0;
        if ($urandom_range(0, 2) == 0) cur_vs = !cur_vs;
        p.vs        = cur_vs;
        p.cursor    = ($urandom_range(0, 1) == 0) ? sq : $urandom_range(0, 63);
        p.select    = ($urandom_range(0, 1) == 0) ? sq : $urandom_range(0, 63);
        p.sel_valid = $urandom_range(0, 1);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input pix_t p, input int gap);
        logic [12:0] exp_g;
        logic [5:0]  hold_b;
        logic [12:0] hold_g;
        exp_g = have_prev ? 13'(glyph_of(prev)) : 13'd0;
        @(negedge clk);
        hcount = 10'(p.h); vcount = 10'(p.v); bright = p.bright;
        hs_in = p.hs; vs_in = p.vs; cursor_sq = 6'(p.cursor); select_sq = 6'(p.select);
        select_valid = p.sel_valid;
        pix_en = 1'b1;
        if (prev_vs && !p.vs) model_fc = (model_fc + 1) % 256;
        prev_vs = p.vs;
        if (have_prev) exp_q.push_back(model(prev, model_fc));
        prev = p;
        have_prev = 1'b1;
        @(posedge clk);
        #1;
        check("board_addr", 32'(board_addr), 32'(square_of(p)));
        check("glyph_addr", 32'(glyph_addr), 32'(exp_g));
        hold_b = board_addr;
        hold_g = glyph_addr;
        for (int k = 0; k < gap; k++) begin
            @(negedge clk);
            pix_en = 1'b0;
            hcount = 10'($urandom_range(0, 1023)); vcount = 10'($urandom_range(0, 1023));
            vs_in = 1'($urandom_range(0, 1)); bright = 1'($urandom_range(0, 1));
            cursor_sq = 6'($urandom_range(0, 63));
            @(posedge clk);
        end
        #1;
        check("addr_hold", 32'({hold_b, hold_g}), 32'({board_addr, glyph_addr}));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
        check({tag, "_sync"}, 32'({hs_out, vs_out, blank_n_out}), 32'b110);
        check({tag, "_addr"}, 32'({board_addr, glyph_addr}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs("reset_async");
        exp_q.delete();
        model_fc = 0;
        prev_vs = 1'b1;
        have_prev = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pix_en = ~pix_en;
        end
        @(negedge clk);
        pix_en = 1'b0;
        rst = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int nstr = 0;
    initial begin
        logic [26:0] e;
        forever begin
            @(posedge clk);
            if (!rst) nstr = 0;
            else if (pix_en) begin
                nstr++;
                #1;
                if (nstr >= 3) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pixel_out: output with no expected entry");
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel_rgb", 32'({vga_r, vga_g, vga_b}), 32'(e[26:3]));
                        check("pixel_sync", 32'({hs_out, vs_out, blank_n_out}), 32'(e[2:0]));
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 64; i++) board[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 8192; i++) glyph_mem[i] = 1'($urandom_range(0, 1));
        board[0]  = 4'h0;
        board[9]  = 4'hB;
        board[63] = 4'h0;
        glyph_mem[{3'd3, 5'd16, 5'd6}] = 1'b1;
        glyph_mem[{3'd3, 5'd16, 5'd7}] = 1'b0;

        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pix_en = ~pix_en;
        end
        #1 check_reset_outputs("reset_hold");
        @(negedge clk);
        pix_en = 1'b0;
        rst = 1'b1;

        // Directed: first pixel, piece glyph, cursor blink, selection corner, stall.
        drive(mk(BX, BY, 1, 1, 1, 63, 0, 0), 1);
        drive(mk(BX + 5, BY + 5, 1, 1, 1, 0, 0, 0), 1);
        drive(mk(BX + 50, BY + 60, 1, 1, 1, 63, 0, 0), 1);
        drive(mk(BX + 51, BY + 60, 1, 1, 1, 63, 0, 0), 1);
        for (int k = 0; k < 16; k++) begin
            drive(mk(700, 500, 0, 1, 0, 63, 0, 0), 1);
            drive(mk(700, 500, 0, 1, 1, 63, 0, 0), 1);
        end
        drive(mk(BX, BY + 5, 1, 1, 1, 0, 0, 0), 1);
        drive(mk(BX + 5, BY + 5, 1, 1, 1, 0, 0, 0), 1);
        drive(mk(BX + 319, BY + 319, 1, 1, 1, 0, 63, 1), 1);
        drive(mk(BX + 320, BY + 319, 1, 1, 1, 0, 63, 1), 10);
        drive(mk(BX + 10, BY + 10, 1, 0, 1, 0, 0, 1), 1);
        drive(mk(BX + 11, BY + 10, 0, 0, 1, 0, 0, 1), 1);
        drive(mk(BX + 12, BY + 10, 1, 1, 1, 0, 0, 1), 1);

        for (int i = 0; i < 2000; i++) begin
            int gap;
            if (i == 1000) do_reset();
            gap = ($urandom_range(0, 49) == 0) ? 10 : $urandom_range(1, 3);
            drive(gen_pix(), gap);
        end
        @(negedge clk);
        check("queue_tail", 32'(exp_q.size()), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/chess_pixel_renderer.md
# chess_pixel_renderer

Pixel-colour stage directly downstream of the VGA timing controller. Takes the controller's pixel counters, sync and bright signals, looks up the piece on the addressed board square in the board-state RAM and the piece's bitmap in the glyph ROM, and produces registered 8-bit RGB. Sync and blank are delayed by the same pipeline depth as the RGB data. It also renders a blinking cursor border and a selected-square highlight.

## Interface
- BOARD_X, 40: hcount of the board's left edge.
- BOARD_Y, 40: vcount of the board's top edge.
- BLINK_BIT, 4: frame-counter bit that gates the cursor border, giving a period of 2^(BLINK_BIT+1) frames.
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel strobe, high one clk in two; all pipeline registers advance only when it is high.
- hcount  in  10  horizontal pixel counter.
- vcount  in  10  vertical pixel counter.
- bright  in  1  visible-area flag.
- hs_in, vs_in  in  1 each  active-low syncs.
- board_addr  out  6  square index, row*8+col; row 0 is the top row.
- board_data  in  4  {colour, type[2:0]}; synchronous read, valid 1 clk after board_addr.
- glyph_addr  out  13  {type[2:0], gy[4:0], gx[4:0]}.
- glyph_bit  in  1  synchronous ROM read, valid 1 clk after glyph_addr.
- cursor_sq  in  6  cursor square index.
- select_sq  in  6  selected square index.
- select_valid  in  1  selection active.
- vga_r, vga_g, vga_b  out  8 each  registered colour.
- hs_out, vs_out, blank_n_out  out  1 each  delayed hs_in, vs_in and bright.

## Operation
- Board area: hcount in [BOARD_X, BOARD_X+320) and vcount in [BOARD_Y, BOARD_Y+320). Squares are 40x40 px.
  - col = (hcount-BOARD_X)/40, row = (vcount-BOARD_Y)/40.
  - sx = (hcount-BOARD_X)%40, sy = (vcount-BOARD_Y)%40.
  - All arithmetic is exact integer arithmetic.
- Stage S0, on pix_en: register inside, row, col, sx, sy, bright and the syncs. board_addr is driven from the S0 registers; it is 0 when outside the board area.
- Stage S1, on pix_en: register board_data together with the S0 fields.
  - Glyph window: sx and sy both in [4,36); gx = sx-4, gy = sy-4.
  - glyph_addr is driven from the S1 registers: {type, gy, gx} inside the window, 0 otherwise.
- Stage S2, on pix_en: register glyph_bit and compute RGB into the output registers. Priority, first match wins:
  1. Registered bright = 0 -> (0,0,0).
  2. Outside the board -> (32,32,32).
  3. Square == cursor_sq, blink bit = 1, and sx or sy in {0,1,38,39} -> (255,0,0).
  4. Piece type in 1..6, inside the glyph window, glyph_bit = 1 -> (255,255,255) when colour = 0, (0,0,0) when colour = 1.
  5. select_valid and square == select_sq -> (246,246,105).
  6. (row+col) even -> (240,217,181); odd -> (181,136,99).
- Types 0 and 7 are empty squares; the glyph is ignored.
- Frame counter: 8 bits. Increments on pix_en when the registered vs_in goes 1->0. It wraps 255->0.
- cursor_sq, select_sq and select_valid are sampled at S0, so a mid-frame change takes effect at the next pixel.

## Timing
- Latency: 3 pix_en strobes from the input counters to vga_r/g/b, hs_out, vs_out and blank_n_out; all of these stay aligned.
- With pix_en low, every register holds. board_addr and glyph_addr are stable for 2 clk, which meets the RAM/ROM 1-clk read latency.
- Reset (asynchronous assert, released synchronously to clk):
  - RGB = 0, blank_n_out = 0, hs_out = 1, vs_out = 1.
  - board_addr = 0, glyph_addr = 0, frame counter = 0, all pipeline registers cleared.
- First valid output: the 3rd pix_en after reset release.
- Reset mid-line: outputs go to their reset values immediately. Rendering resumes at whatever counters arrive; no realignment is needed.
- Boundary pixels:
  - hcount = BOARD_X+319 is inside the board; BOARD_X+320 is outside.
  - sx = 36 is outside the glyph window.
  - Cursor and selection on the same square: the cursor border wins on border pixels, the highlight fills the remainder.

## Test plan
- Reset: hold rst low, toggle pix_en -> RGB 0, hs_out/vs_out 1, blank_n_out 0. Release, drive hcount=40, vcount=40, bright=1, board_data=0 -> after 3 strobes RGB = (240,217,181) and board_addr = 0.
- Piece: square 9 = {1,3}, hcount=BOARD_X+40+10, vcount=BOARD_Y+40+20 -> glyph_addr = {3,16,6}. With glyph_bit=1 -> RGB (0,0,0); with glyph_bit=0 -> (240,217,181).
- Cursor: cursor_sq=0, force the frame counter to 16 (BLINK_BIT=4) with sx=0 -> (255,0,0). Frame counter 0 -> square colour.
- Selection: select_valid=1, select_sq=63, pixel (BOARD_X+319, BOARD_Y+319) -> (246,246,105). Next hcount -> (32,32,32).
- Pipeline hold: stall pix_en low for 10 clk mid-line -> outputs and addresses frozen, no pixel skipped or duplicated.
- Sync alignment: a pulse on hs_in and a bright edge -> hs_out and blank_n_out change exactly 3 strobes later, coincident with the RGB change.
